// File: rtl/fp_mul_seq_if.sv
// Operand/result handshake bundle for the sequential single-precision multiplier.
// The master drives operands and consumes results; the slave is the multiplier.
interface fp_mul_seq_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a;
   logic [31:0] b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;

   modport master (
      output in_valid, a, b, out_ready,
      input  in_ready, out_valid, result
   );

   modport slave (
      input  in_valid, a, b, out_ready,
      output in_ready, out_valid, result
   );
endinterface

// File: rtl/fp_mul_seq.sv
// Sequential IEEE-754 single multiplier: 24-cycle shift-add, one normalise cycle, flush-to-zero.
// Optional round-to-nearest-even when FP_MUL_ROUND_EN is defined; truncation otherwise.
module fp_mul_seq (
   input  logic        clk,
   input  logic        rst,
   fp_mul_seq_if.slave bus
);
   typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;

   state_t             state_q, state_d;
   logic        [47:0] acc_q, acc_d;
   logic        [4:0]  cnt_q, cnt_d;
   logic        [23:0] mcand_q, mcand_d;
   logic        [23:0] mplier_q, mplier_d;
   logic signed [9:0]  exp_q, exp_d;
   logic               sign_q, sign_d;
   logic               nan_q, nan_d;
   logic               inf_q, inf_d;
   logic               zero_q, zero_d;
   logic        [31:0] result_q, result_d;

   logic [7:0] ea, eb;
   logic       a_nan, b_nan, a_inf, b_inf;

   logic                hi;
   logic        [22:0]  mant_t, mant_f;
   logic                grd, stk;
   logic signed [10:0]  exp_n, exp_f;
`ifdef FP_MUL_ROUND_EN
   logic                rnd_carry;
`else
   logic                unused_rnd;
`endif

   function automatic logic [23:0] round_rne(input logic [22:0] mant, input logic guard,
                                             input logic sticky);
      logic up;
      up = guard & (sticky | mant[0]);
      return {1'b0, mant} + {23'd0, up};
   endfunction

   function automatic logic [31:0] pack_sat(input logic sign, input logic signed [10:0] e,
                                            input logic [22:0] mant);
      if (e >= 11'sd255)    return {sign, 8'hFF, 23'd0};
      else if (e <= 11'sd0) return {sign, 31'd0};
      else                  return {sign, e[7:0], mant};
   endfunction

   assign ea    = bus.a[30:23];
   assign eb    = bus.b[30:23];
   assign a_nan = (ea == 8'hFF) && (bus.a[22:0] != 23'd0);
   assign b_nan = (eb == 8'hFF) && (bus.b[22:0] != 23'd0);
   assign a_inf = (ea == 8'hFF) && (bus.a[22:0] == 23'd0);
   assign b_inf = (eb == 8'hFF) && (bus.b[22:0] == 23'd0);

   // Normalise: product of two 1.x significands lies in [1,4), so only bit 47 decides the shift.
   always_comb begin
      hi     = acc_q[47];
      mant_t = hi ? acc_q[46:24] : acc_q[45:23];
      grd    = hi ? acc_q[23] : acc_q[22];
      stk    = hi ? (|acc_q[22:0]) : (|acc_q[21:0]);
      exp_n  = $signed({exp_q[9], exp_q}) + (hi ? 11'sd1 : 11'sd0);
`ifdef FP_MUL_ROUND_EN
      {rnd_carry, mant_f} = round_rne(mant_t, grd, stk);
      exp_f = exp_n + (rnd_carry ? 11'sd1 : 11'sd0);
`else
      mant_f     = mant_t;
      exp_f      = exp_n;
      unused_rnd = grd ^ stk;
`endif
   end

   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      exp_d    = exp_q;
      sign_d   = sign_q;
      nan_d    = nan_q;
      inf_d    = inf_q;
      zero_d   = zero_q;
      result_d = result_q;
      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               sign_d   = bus.a[31] ^ bus.b[31];
               exp_d    = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;
               mcand_d  = {1'b1, bus.a[22:0]};
               mplier_d = {1'b1, bus.b[22:0]};
               nan_d    = a_nan | b_nan;
               inf_d    = a_inf | b_inf;
               zero_d   = (ea == 8'd0) | (eb == 8'd0);
               acc_d    = 48'd0;
               cnt_d    = 5'd0;
               state_d  = MUL;
            end
         end
         MUL: begin
            if (mplier_q[cnt_q]) acc_d = acc_q + ({24'd0, mcand_q} << cnt_q);
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd23) state_d = NORM;
         end
         NORM: begin
            // Specials ride the same timeline so latency never depends on operand class.
            if (nan_q || (inf_q && zero_q)) result_d = 32'h7FC0_0000;
            else if (inf_q)                 result_d = {sign_q, 8'hFF, 23'd0};
            else if (zero_q)                result_d = {sign_q, 31'd0};
            else                            result_d = pack_sat(sign_q, exp_f, mant_f);
            state_d = DONE;
         end
         DONE: begin
            if (bus.out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         acc_q    <= 48'd0;
         cnt_q    <= 5'd0;
         mcand_q  <= 24'd0;
         mplier_q <= 24'd0;
         exp_q    <= 10'sd0;
         sign_q   <= 1'b0;
         nan_q    <= 1'b0;
         inf_q    <= 1'b0;
         zero_q   <= 1'b0;
         result_q <= 32'd0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         exp_q    <= exp_d;
         sign_q   <= sign_d;
         nan_q    <= nan_d;
         inf_q    <= inf_d;
         zero_q   <= zero_d;
         result_q <= result_d;
      end
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.result    = result_q;
endmodule

// File: tb/tb_fp_mul_seq.sv
// Directed bench for fp_mul_seq: latency, specials, flush/saturate, rounding, back-pressure, reset abort.
module tb_fp_mul_seq;
   logic clk;
   logic rst;
   int   checks;
   int   errors;

   fp_mul_seq_if bus ();

   fp_mul_seq dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   // Starts and ends on a negedge; hold3 adds three cycles of out_ready=0 in DONE.
   task automatic do_op(input string tag, input logic [31:0] ta, input logic [31:0] tb,
                        input logic [31:0] exp_r, input bit hold3);
      int n;
      logic [31:0] held;
      n = 0;
      while (!bus.in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
      bus.a        = ta;
      bus.b        = tb;
      bus.in_valid = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.a        = 32'hDEAD_BEEF;
      bus.b        = 32'h1234_5678;
      n = 0;
      while (!bus.out_valid && n < 60) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_latency"}, n, 32'd25);
      check(tag, bus.result, exp_r);
      if (hold3) begin
         held = bus.result;
         repeat (3) begin
            @(negedge clk);
            check({tag, "_hold_res"}, bus.result, held);
            check({tag, "_hold_vld"}, {31'd0, bus.out_valid}, 32'd1);
            check({tag, "_hold_rdy"}, {31'd0, bus.in_ready}, 32'd0);
         end
      end
      bus.out_ready = 1'b1;
      check({tag, "_rdy_pre"}, {31'd0, bus.in_ready}, 32'd0);
      @(negedge clk);
      bus.out_ready = 1'b0;
      check({tag, "_vld_post"}, {31'd0, bus.out_valid}, 32'd0);
      check({tag, "_rdy_post"}, {31'd0, bus.in_ready}, 32'd1);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      checks        = 0;
      errors        = 0;
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.a         = 32'd0;
      bus.b         = 32'd0;
      bus.out_ready = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
      check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("rst_result",    bus.result,             32'd0);

      do_op("mul_1p5x2",   32'h3FC0_0000, 32'h4000_0000, 32'h4040_0000, 1'b1);
      do_op("neg2xhalf",   32'hC000_0000, 32'h3F00_0000, 32'hBF80_0000, 1'b0);
      do_op("overflow",    32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000, 1'b0);
      do_op("inf_x_zero",  32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000, 1'b0);
      do_op("subnorm_ftz", 32'h0000_0001, 32'h3F80_0000, 32'h0000_0000, 1'b0);
`ifdef FP_MUL_ROUND_EN
      do_op("round",       32'h3F80_0001, 32'h3FC0_0000, 32'h3FC0_0002, 1'b0);
`else
      do_op("round",       32'h3F80_0001, 32'h3FC0_0000, 32'h3FC0_0001, 1'b0);
`endif
      do_op("nan_in",      32'h7FC0_0000, 32'h3F80_0000, 32'h7FC0_0000, 1'b0);
      do_op("neginf_x2",   32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, 1'b0);
      do_op("negzero_x3",  32'h8000_0000, 32'h4040_0000, 32'h8000_0000, 1'b0);
      do_op("underflow",   32'h0080_0000, 32'h3F00_0000, 32'h0000_0000, 1'b0);
      do_op("norm_hi",     32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000, 1'b0);

      // Abort mid-MUL: the previous result must be wiped and nothing delivered.
      bus.a        = 32'h4000_0000;
      bus.b        = 32'h4000_0000;
      bus.in_valid = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (10) @(negedge clk);
      check("abort_busy", {31'd0, bus.in_ready}, 32'd0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("abort_result",    bus.result,             32'd0);
      check("abort_in_ready",  {31'd0, bus.in_ready},  32'd1);
      n = 0;
      repeat (30) begin
         @(negedge clk);
         if (bus.out_valid) n++;
      end
      check("abort_no_deliver", n, 32'd0);
      do_op("after_abort", 32'h3FC0_0000, 32'h4000_0000, 32'h4040_0000, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
